// File: rtl/gpu_dispatcher_pkg.sv
// Shared definitions for the GPU job dispatcher: FSM state encoding and
// default widths/addresses used by the top level.
package gpu_dispatcher_pkg;

  localparam int          DEF_WIDTH        = 32;
  localparam logic [31:0] DEF_MAILBOX_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/gpu_dispatcher_cmd_fifo.sv
// Command FIFO: power-of-two depth circular buffer with occupancy count.
// Head entry is presented combinationally on pop_data.
module cmd_fifo
  import gpu_dispatcher_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Guard against overflow/underflow so the pointers never drift.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  assign full     = (r_count == CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];

  // Storage array carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_dispatcher.sv
// GPU job dispatcher: queues host commands, writes each one to the shared
// mailbox word, raises a start pulse and waits for the finish pulse or a
// timeout before taking the next job.
module gpu_dispatcher
  import gpu_dispatcher_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter int               FIFO_DEPTH   = 4,
  parameter logic [WIDTH-1:0] MAILBOX_ADDR = WIDTH'(DEF_MAILBOX_ADDR),
  parameter int               TIMEOUT      = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_wren,
  output logic             interrupt_start,
  input  logic             interrupt_finish,
  output logic             busy,
  output logic [15:0]      done_count,
  output logic             error
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_job;
  logic [TMO_W-1:0] r_tmo;
  logic [15:0]      r_done_count;
  logic             r_error;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_finish;
  logic             w_tmo_hit;

  assign cmd_ready = (w_count < CNT_W'(FIFO_DEPTH));
  assign w_push    = cmd_valid && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;

  // Finish is only meaningful while waiting; the timeout fires on the
  // TIMEOUT-th WAIT cycle, and a coincident finish takes priority.
  assign w_finish  = (r_state == S_WAIT) && interrupt_finish;
  assign w_tmo_hit = (r_state == S_WAIT) && (r_tmo == TMO_W'(TIMEOUT - 1));

  cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (cmd_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: IDLE -> WRITE -> START -> WAIT -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_WRITE;
      S_WRITE: w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (w_finish || w_tmo_hit) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Job register captures the FIFO head as it is popped.
  always_ff @(posedge clk) begin
    if (w_pop) r_job <= w_head;
  end

  // Timeout counter: cleared on START, counts WAIT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    r_tmo <= '0;
    else if (r_state == S_START)                  r_tmo <= '0;
    else if (r_state == S_WAIT && !w_finish && !w_tmo_hit)
                                                  r_tmo <= r_tmo + TMO_W'(1);
  end

  // Completed-job counter wraps naturally at 16 bits; error is sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done_count <= '0;
      r_error      <= 1'b0;
    end else begin
      if (w_finish)                       r_done_count <= r_done_count + 16'd1;
      if (w_tmo_hit && !interrupt_finish) r_error      <= 1'b1;
    end
  end

  // Outputs decode from state (and the registered job), so they drop
  // immediately when reset asserts.
  assign mem_wren        = (r_state == S_WRITE);
  assign mem_address     = mem_wren ? MAILBOX_ADDR : '0;
  assign mem_wdata       = mem_wren ? r_job : '0;
  assign interrupt_start = (r_state == S_START);
  assign busy            = !w_empty || (r_state != S_IDLE);
  assign done_count      = r_done_count;
  assign error           = r_error;

endmodule

// File: tb/tb_gpu_dispatcher.sv
// Directed bench for gpu_dispatcher: one instance with the default timeout
// and one with TIMEOUT=8 for the abandon/coincidence cases.
module tb_gpu_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  int          n_cmp  = 0;
  int          n_fail = 0;

  // Default-timeout instance.
  logic [31:0] d_cmd_data;
  logic        d_cmd_valid, d_cmd_ready, d_wren, d_start, d_finish, d_busy, d_error;
  logic [31:0] d_addr, d_wdata;
  logic [15:0] d_done;

  // TIMEOUT=8 instance.
  logic [31:0] t_cmd_data;
  logic        t_cmd_valid, t_cmd_ready, t_wren, t_start, t_finish, t_busy, t_error;
  logic [31:0] t_addr, t_wdata;
  logic [15:0] t_done;

  logic [31:0] words [5];

  always #5 clk = ~clk;

  gpu_dispatcher u_dut (
    .clk(clk), .reset(reset),
    .cmd_data(d_cmd_data), .cmd_valid(d_cmd_valid), .cmd_ready(d_cmd_ready),
    .mem_address(d_addr), .mem_wdata(d_wdata), .mem_wren(d_wren),
    .interrupt_start(d_start), .interrupt_finish(d_finish),
    .busy(d_busy), .done_count(d_done), .error(d_error)
  );

  gpu_dispatcher #(.TIMEOUT(8)) u_tmo (
    .clk(clk), .reset(reset),
    .cmd_data(t_cmd_data), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
    .mem_address(t_addr), .mem_wdata(t_wdata), .mem_wren(t_wren),
    .interrupt_start(t_start), .interrupt_finish(t_finish),
    .busy(t_busy), .done_count(t_done), .error(t_error)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance until the selected instance shows mem_wren, with a cycle bound.
  task automatic wait_wren(input bit sel, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if ((sel ? t_wren : d_wren) === 1'b1) seen = 1'b1;
      else tick();
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic pulse_finish(input bit sel);
    if (sel) t_finish = 1'b1; else d_finish = 1'b1;
    tick();
    t_finish = 1'b0;
    d_finish = 1'b0;
  endtask

  initial begin
    words[0] = 32'h1111_0001; words[1] = 32'h2222_0002; words[2] = 32'h3333_0003;
    words[3] = 32'h4444_0004; words[4] = 32'h5555_0005;
    reset = 1'b1;
    d_cmd_data = '0; d_cmd_valid = 1'b0; d_finish = 1'b0;
    t_cmd_data = '0; t_cmd_valid = 1'b0; t_finish = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state on both instances.
    chk("rst_ready", {31'd0, d_cmd_ready}, 32'd1);
    chk("rst_busy",  {31'd0, d_busy},      32'd0);
    chk("rst_wren",  {31'd0, d_wren},      32'd0);
    chk("rst_addr",  d_addr,               32'd0);
    chk("rst_wdata", d_wdata,              32'd0);
    chk("rst_start", {31'd0, d_start},     32'd0);
    chk("rst_done",  {16'd0, d_done},      32'd0);
    chk("rst_error", {31'd0, d_error},     32'd0);
    chk("rst_t_ready", {31'd0, t_cmd_ready}, 32'd1);
    chk("rst_t_error", {31'd0, t_error},     32'd0);

    // Single job latency: wren in cycle 2, start in cycle 3.
    d_cmd_data = 32'hDEAD_BEEF; d_cmd_valid = 1'b1;
    tick();
    d_cmd_valid = 1'b0;
    chk("lat_c1_wren", {31'd0, d_wren}, 32'd0);
    chk("lat_c1_busy", {31'd0, d_busy}, 32'd1);
    tick();
    chk("lat_c2_wren",  {31'd0, d_wren},  32'd1);
    chk("lat_c2_addr",  d_addr,           32'd0);
    chk("lat_c2_wdata", d_wdata,          32'hDEAD_BEEF);
    chk("lat_c2_start", {31'd0, d_start}, 32'd0);
    tick();
    chk("lat_c3_start", {31'd0, d_start}, 32'd1);
    chk("lat_c3_wren",  {31'd0, d_wren},  32'd0);
    chk("lat_c3_wdata", d_wdata,          32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("wait_no_start", {31'd0, d_start}, 32'd0);
    pulse_finish(1'b0);
    chk("job1_done", {16'd0, d_done}, 32'd1);
    chk("job1_busy", {31'd0, d_busy}, 32'd0);

    // Five pushes with finish withheld; the first is popped immediately.
    for (int i = 0; i < 5; i++) begin
      d_cmd_data = words[i]; d_cmd_valid = 1'b1;
      chk($sformatf("q_ready_%0d", i), {31'd0, d_cmd_ready}, 32'd1);
      if (i == 2) chk("q_w0_wdata", d_wdata, words[0]);
      tick();
    end
    d_cmd_valid = 1'b0;
    chk("q_full_ready", {31'd0, d_cmd_ready}, 32'd0);
    chk("q_full_busy",  {31'd0, d_busy},      32'd1);
    pulse_finish(1'b0);
    for (int i = 1; i < 5; i++) begin
      wait_wren(1'b0, $sformatf("q_wren_%0d", i));
      chk($sformatf("q_wdata_%0d", i), d_wdata, words[i]);
      tick();
      tick();
      pulse_finish(1'b0);
    end
    chk("q_done",  {16'd0, d_done},      32'd6);
    chk("q_busy",  {31'd0, d_busy},      32'd0);
    chk("q_ready", {31'd0, d_cmd_ready}, 32'd1);

    // Finish while idle is ignored.
    pulse_finish(1'b0);
    chk("idle_finish_done", {16'd0, d_done}, 32'd6);

    // TIMEOUT=8 instance: job A finishes exactly on the timeout cycle.
    t_cmd_data = 32'hA0A0_0001; t_cmd_valid = 1'b1;
    tick();
    t_cmd_valid = 1'b0;
    wait_wren(1'b1, "tA_wren");
    chk("tA_wdata", t_wdata, 32'hA0A0_0001);
    tick();
    chk("tA_start", {31'd0, t_start}, 32'd1);
    tick();
    t_cmd_data = 32'hB0B0_0002; t_cmd_valid = 1'b1;
    tick();
    t_cmd_data = 32'hC0C0_0003;
    tick();
    t_cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("tA_err_w8", {31'd0, t_error}, 32'd0);
    pulse_finish(1'b1);
    chk("tA_done",  {16'd0, t_done},  32'd1);
    chk("tA_error", {31'd0, t_error}, 32'd0);

    // Job B times out after 8 WAIT cycles.
    wait_wren(1'b1, "tB_wren");
    chk("tB_wdata", t_wdata, 32'hB0B0_0002);
    tick();
    chk("tB_start", {31'd0, t_start}, 32'd1);
    for (int i = 0; i < 8; i++) tick();
    chk("tB_err_w8", {31'd0, t_error}, 32'd0);
    tick();
    chk("tB_error", {31'd0, t_error}, 32'd1);
    chk("tB_done",  {16'd0, t_done},  32'd1);
    chk("tB_busy",  {31'd0, t_busy},  32'd1);

    // Job C proceeds after the timeout; error remains sticky.
    wait_wren(1'b1, "tC_wren");
    chk("tC_wdata", t_wdata, 32'hC0C0_0003);
    tick();
    tick();
    pulse_finish(1'b1);
    chk("tC_done",  {16'd0, t_done},  32'd2);
    chk("tC_error", {31'd0, t_error}, 32'd1);
    chk("tC_busy",  {31'd0, t_busy},  32'd0);

    // Reset while waiting with two words queued.
    d_cmd_data = 32'hD0D0_0004; d_cmd_valid = 1'b1;
    tick();
    d_cmd_valid = 1'b0;
    wait_wren(1'b0, "rD_wren");
    tick();
    tick();
    d_cmd_data = 32'hE0E0_0005; d_cmd_valid = 1'b1;
    tick();
    d_cmd_data = 32'hF0F0_0006;
    tick();
    d_cmd_valid = 1'b0;
    chk("rD_busy_pre",  {31'd0, d_busy},      32'd1);
    chk("rD_ready_pre", {31'd0, d_cmd_ready}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_busy",  {31'd0, d_busy},      32'd0);
    chk("ar_ready", {31'd0, d_cmd_ready}, 32'd1);
    chk("ar_wren",  {31'd0, d_wren},      32'd0);
    chk("ar_wdata", d_wdata,              32'd0);
    chk("ar_start", {31'd0, d_start},     32'd0);
    chk("ar_done",  {16'd0, d_done},      32'd0);
    chk("ar_error", {31'd0, t_error},     32'd0);
    tick();
    reset = 1'b0;
    chk("ar_rel_start", {31'd0, d_start}, 32'd0);
    chk("ar_rel_wren",  {31'd0, d_wren},  32'd0);
    pulse_finish(1'b0);
    tick();
    chk("ar_late_finish", {16'd0, d_done}, 32'd0);
    chk("ar_late_wren",   {31'd0, d_wren}, 32'd0);
    chk("ar_late_busy",   {31'd0, d_busy}, 32'd0);

    // Wrap: preload the counter to FFFF, then complete one job.
    force u_dut.r_done_count = 16'hFFFF;
    #1 release u_dut.r_done_count;
    @(negedge clk);
    chk("wrap_pre", {16'd0, d_done}, 32'h0000_FFFF);
    d_cmd_data = 32'h1234_5678; d_cmd_valid = 1'b1;
    tick();
    d_cmd_valid = 1'b0;
    wait_wren(1'b0, "wrap_wren");
    tick();
    tick();
    pulse_finish(1'b0);
    chk("wrap_done", {16'd0, d_done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
